pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage pipeline.
- Resolves the MEM-stage redirect (jal, beq, bne) into PC source select and younger-stage flushes.
- Detects load-use hazards in ID and freezes the whole pipeline while a multi-cycle data-memory access in MEM is not ready.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
CNT_W, 32, width of each performance counter
TO_CYC, 64, maximum consecutive wait cycles before mem_err sets (≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
jump_mem  in  1  jal in MEM
branch_mem  in  1  beq in MEM
branchn_mem  in  1  bne in MEM
zero_mem  in  1  ALU zero of MEM-stage instruction
memreq_mem  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
memread_ex  in  1  EX-stage instruction is a load
rd_ex  in  5  EX-stage destination register
rs1_id, rs2_id  in  5 each  ID-stage source registers
rs1_used_id, rs2_used_id  in  1 each  source actually read
cnt_clr  in  1  synchronous clear of counters and mem_err
pcsrc  out  1  1 = PC takes branch/jump target
pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  pipeline register enables
ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear to bubble; overrides the write enable
stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  performance counters
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: while rst=1,
  - pcsrc=0; all *_write=0; all *_flush=1.
  - State←RUN; all counters←0; mem_err←0; internal wait timer←0.
- Decode (combinational):
  - redirect = jump_mem | (branch_mem & zero_mem) | (branchn_mem & ~zero_mem).
  - mwait = memreq_mem & ~mem_ready.
  - lu = memread_ex & (rd_ex≠0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Priority, highest first; control outputs are combinational and take effect in the same cycle.
  1. mwait: all *_write=0, all flushes=0, pcsrc=0. Full freeze.
  2. redirect: pcsrc=1; ifid_flush=idex_flush=exmem_flush=1; all writes=1. The 3 younger instructions are killed.
  3. lu: pc_write=0, ifid_write=0, idex_flush=1; other writes=1. One bubble is inserted.
  4. Otherwise: all writes=1, no flush, pcsrc=0.
- Simultaneous events:
  - redirect with mwait: redirect is deferred. Frozen MEM inputs persist, so it fires in the first non-wait cycle.
  - redirect with lu: redirect wins and lu is discarded, since the ID instruction is flushed.
- State machine (registered; outputs do not depend on state):
  - RUN→WAIT when mwait.
  - WAIT→RUN when ~mwait.
  - The wait timer increments each WAIT cycle and clears on exit.
  - When the timer reaches TO_CYC-1 while still waiting, mem_err←1 (sticky until rst or cnt_clr). The freeze continues regardless.
- Counters, one increment per qualifying cycle, saturating at all-ones (no wrap):
  - stall_cnt: cycles with lu active and not overridden.
  - flush_cnt: cycles with redirect taken.
  - wait_cnt: cycles with mwait.
- cnt_clr: zeros the counters and mem_err next edge and wins over increment in the same cycle. It does not affect state or the control outputs.
- Reset mid-wait: the state returns to RUN. The pipeline is flushed through the *_flush outputs held at 1.

Test Plan:
- Reset: rst=1 for 2 cycles → pcsrc=0, all writes=0, all flushes=1, counters=0, mem_err=0. Release rst → all writes=1, flushes=0.
- beq taken: branch_mem=1, zero_mem=1 for one cycle → pcsrc=1, 3 flushes=1 that cycle, flush_cnt=1. Same with zero_mem=0 → no redirect, flush_cnt stays 1. bne with zero_mem=0 → redirect, flush_cnt=2.
- Load-use: memread_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 → pc_write=0, ifid_write=0, idex_flush=1, stall_cnt+1. Same with rd_ex=0 → no stall.
- Mem wait with deferred redirect: memreq_mem=1, mem_ready=0 for 3 cycles with jump_mem=1 → all writes=0, pcsrc=0, wait_cnt=3. On mem_ready=1 → pcsrc=1 that cycle.
- Timeout: TO_CYC=4, mem_ready=0 for 5 cycles → mem_err=1 after the 4th wait cycle, stays set after ready. cnt_clr=1 → mem_err=0 and all counters=0 next cycle.
- Saturation: CNT_W=3, 9 consecutive lu cycles → stall_cnt holds at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline. It also keeps
// saturating event counters and a sticky data-memory timeout flag.
module pipeline_hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int TO_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_mem,
    input  logic             branch_mem,
    input  logic             branchn_mem,
    input  logic             zero_mem,
    input  logic             memreq_mem,
    input  logic             mem_ready,
    input  logic             memread_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             cnt_clr,
    output logic             pcsrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_err
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    localparam int            TW     = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic              memErr_q, memErr_d;

    logic redirect, mwait, lu;
    logic stallHit, flushHit;

    assign redirect = jump_mem | (branch_mem & zero_mem) | (branchn_mem & ~zero_mem);
    assign mwait    = memreq_mem & ~mem_ready;
    assign lu       = memread_ex & (rd_ex != 5'd0) &
                      ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

    // A memory wait masks both other events; a redirect kills the stalled ID instruction.
    assign stallHit = lu & ~redirect & ~mwait;
    assign flushHit = redirect & ~mwait;

    always_comb begin
        pcsrc       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mwait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (redirect) begin
            pcsrc       = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        waitCnt_d  = waitCnt_q;
        memErr_d   = memErr_q;

        case (state_q)
            S_RUN:   if (mwait)  state_d = S_WAIT;
            S_WAIT:  if (!mwait) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        // Timer holds at its limit so a long wait cannot wrap it back to zero.
        if (!mwait) begin
            timer_d = '0;
        end else if (state_q == S_RUN) begin
            timer_d = TW'(1);
        end else if (timer_q != TO_LIM) begin
            timer_d = timer_q + TW'(1);
        end

        if (cnt_clr) begin
            stallCnt_d = '0;
            flushCnt_d = '0;
            waitCnt_d  = '0;
            memErr_d   = 1'b0;
        end else begin
            if (stallHit && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
            if (flushHit && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
            if (mwait && (waitCnt_q != '1))     waitCnt_d  = waitCnt_q + CNT_W'(1);
            if (mwait && (timer_q == TO_LIM))   memErr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            timer_q    <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
            waitCnt_q  <= '0;
            memErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            waitCnt_q  <= waitCnt_d;
            memErr_q   <= memErr_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;
    assign wait_cnt  = waitCnt_q;
    assign mem_err   = memErr_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with 3-bit counters and a 4-cycle
// timeout, so saturation and timeout are both reachable in a short run.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W  = 3;
    localparam int TO_CYC = 4;
    localparam int CMAX   = 7;

    logic       clk;
    logic       rst;
    logic       jump_mem, branch_mem, branchn_mem, zero_mem;
    logic       memreq_mem, mem_ready, memread_ex;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       rs1_used_id, rs2_used_id, cnt_clr;
    logic       pcsrc, pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic       mem_err;

    logic [18:0] obsVec;
    logic [18:0] sb[$];
    int          nChecks = 0;
    int          nFail   = 0;
    int          mStall  = 0;
    int          mFlush  = 0;
    int          mWait   = 0;
    int          mTimer  = 0;
    logic        mErr    = 1'b0;

    pipeline_hazard_ctrl #(
        .CNT_W (CNT_W),
        .TO_CYC(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jump_mem   (jump_mem),
        .branch_mem (branch_mem),
        .branchn_mem(branchn_mem),
        .zero_mem   (zero_mem),
        .memreq_mem (memreq_mem),
        .mem_ready  (mem_ready),
        .memread_ex (memread_ex),
        .rd_ex      (rd_ex),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id),
        .cnt_clr    (cnt_clr),
        .pcsrc      (pcsrc),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .idex_write (idex_write),
        .exmem_write(exmem_write),
        .memwb_write(memwb_write),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .exmem_flush(exmem_flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .wait_cnt   (wait_cnt),
        .mem_err    (mem_err)
    );

    assign obsVec = {pcsrc, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                     ifid_flush, idex_flush, exmem_flush, stall_cnt, flush_cnt, wait_cnt, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic decode(output logic mw, output logic rdr, output logic lu);
        mw  = memreq_mem & ~mem_ready;
        rdr = jump_mem | (branch_mem & zero_mem) | (branchn_mem & ~zero_mem);
        lu  = memread_ex & (rd_ex != 5'd0) &
              ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
    endtask

    // Expected control outputs come from the current inputs, counters from the model.
    task automatic step();
        logic mw, rdr, lu, pc;
        logic [4:0] w;
        logic [2:0] f;
        decode(mw, rdr, lu);
        pc = 1'b0;
        w  = 5'b11111;
        f  = 3'b000;
        if (rst) begin
            w = 5'b00000;
            f = 3'b111;
        end else if (mw) begin
            w = 5'b00000;
        end else if (rdr) begin
            pc = 1'b1;
            f  = 3'b111;
        end else if (lu) begin
            w = 5'b00111;
            f = 3'b010;
        end
        sb.push_back({pc, w, f, 3'(mStall), 3'(mFlush), 3'(mWait), mErr});
        @(negedge clk);
    endtask

    task automatic tick();
        logic mw, rdr, lu;
        decode(mw, rdr, lu);
        @(posedge clk);
        if (rst) begin
            mStall = 0;
            mFlush = 0;
            mWait  = 0;
            mErr   = 1'b0;
            mTimer = 0;
        end else begin
            if (cnt_clr) begin
                mStall = 0;
                mFlush = 0;
                mWait  = 0;
                mErr   = 1'b0;
            end else begin
                if (lu && !rdr && !mw && mStall < CMAX) mStall++;
                if (rdr && !mw && mFlush < CMAX)        mFlush++;
                if (mw && mWait < CMAX)                 mWait++;
                if (mw && mTimer >= TO_CYC - 1)         mErr = 1'b1;
            end
            mTimer = mw ? mTimer + 1 : 0;
        end
        #1;
    endtask

    task automatic clearInputs();
        jump_mem = 0; branch_mem = 0; branchn_mem = 0; zero_mem = 0;
        memreq_mem = 0; mem_ready = 0; memread_ex = 0;
        rd_ex = 0; rs1_id = 0; rs2_id = 0;
        rs1_used_id = 0; rs2_used_id = 0; cnt_clr = 0;
    endtask

    task automatic setLu(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2);
        memread_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
        rs1_used_id = u1; rs2_used_id = u2;
    endtask

    task automatic test_reset();
        logic [18:0] expv;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL reset cycle %0d: got %b expected %b", i, obsVec, expv);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [18:0] expv;
        logic [2:0]  pat [3];
        pat[0] = 3'b101;
        pat[1] = 3'b100;
        pat[2] = 3'b010;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) {branch_mem, branchn_mem, zero_mem} = pat[i];
            else       {branch_mem, branchn_mem, zero_mem} = 3'b000;
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL branch pattern %0d: got %b expected %b", i, obsVec, expv);
            end
            tick();
        end
        nChecks++;
        if (flush_cnt !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL branch flush_cnt: got %0d expected 2", flush_cnt);
        end
    endtask

    task automatic test_load_use();
        logic [18:0] expv;
        for (int i = 0; i < 7; i++) begin
            clearInputs();
            case (i)
                0: setLu(1, 5, 0, 5, 0, 1);
                1: setLu(1, 0, 0, 0, 1, 1);
                2: setLu(1, 7, 7, 3, 0, 1);
                3: setLu(1, 9, 9, 0, 1, 0);
                4: setLu(0, 5, 5, 5, 1, 1);
                5: begin
                    setLu(1, 5, 0, 5, 0, 1);
                    branch_mem = 1; zero_mem = 1;
                end
                default: ;
            endcase
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL load_use case %0d: got %b expected %b", i, obsVec, expv);
            end
            tick();
        end
        nChecks++;
        if (stall_cnt !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL load_use stall_cnt: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [18:0] expv;
        clearInputs();
        jump_mem = 1; memreq_mem = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL mem_wait cycle %0d: got %b expected %b", i, obsVec, expv);
            end
            if (i == 3) begin
                nChecks++;
                if (pcsrc !== 1'b1 || wait_cnt !== 3'd3) begin
                    nFail++;
                    $display("[TB] FAIL mem_wait release: got pcsrc=%b wait=%0d expected pcsrc=1 wait=3",
                             pcsrc, wait_cnt);
                end
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_timeout();
        logic [18:0] expv;
        clearInputs();
        memreq_mem = 1;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i >= 5);
            if (i >= 6) memreq_mem = 0;
            cnt_clr = (i == 6);
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL timeout cycle %0d: got %b expected %b", i, obsVec, expv);
            end
            if (i == 5) begin
                nChecks++;
                if (mem_err !== 1'b1 || wait_cnt !== 3'd7) begin
                    nFail++;
                    $display("[TB] FAIL timeout sticky: got err=%b wait=%0d expected err=1 wait=7",
                             mem_err, wait_cnt);
                end
            end
            if (i == 7) begin
                nChecks++;
                if ({stall_cnt, flush_cnt, wait_cnt, mem_err} !== 10'd0) begin
                    nFail++;
                    $display("[TB] FAIL timeout clear: got %0d/%0d/%0d err=%b expected all zero",
                             stall_cnt, flush_cnt, wait_cnt, mem_err);
                end
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_saturation();
        logic [18:0] expv;
        for (int i = 0; i < 12; i++) begin
            clearInputs();
            if (i < 9 || i == 10) setLu(1, 5, 0, 5, 0, 1);
            cnt_clr = (i == 10);
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL saturation cycle %0d: got %b expected %b", i, obsVec, expv);
            end
            if (i == 9) begin
                nChecks++;
                if (stall_cnt !== 3'd7) begin
                    nFail++;
                    $display("[TB] FAIL saturation hold: got %0d expected 7", stall_cnt);
                end
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_reset_midwait();
        logic [18:0] expv;
        clearInputs();
        memreq_mem = 1;
        for (int i = 0; i < 6; i++) begin
            rst = (i == 2);
            if (i == 5) memreq_mem = 0;
            step();
            expv = sb.pop_front();
            nChecks++;
            if (obsVec !== expv) begin
                nFail++;
                $display("[TB] FAIL reset_midwait cycle %0d: got %b expected %b", i, obsVec, expv);
            end
            tick();
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_midwait();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
